// File: rtl/fpdoom_pkg.sv
// Shared definitions for the raycaster camera path: heading table geometry,
// angle_rom word layout and the heading controller state encoding.
package fpdoom_pkg;

    localparam int NUM_ANGLES = 126;
    localparam int ANGLE_W    = 7;
    localparam int ROM_W      = 80;
    localparam int FIELD_W    = 16;

    // Bit offsets of each Q8.8 field inside one angle_rom word
    localparam int DIR_X_LSB   = 64;
    localparam int DIR_Y_LSB   = 48;
    localparam int PLANE_X_LSB = 32;
    localparam int PLANE_Y_LSB = 16;
    localparam int INV_DET_LSB = 0;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_REQ  = 2'd2,
        ST_CAPT = 2'd3
    } state_t;

endpackage

// File: rtl/heading_step.sv
// Combinational modular step of the heading index: +TURN_STEP for a right
// turn, -TURN_STEP for a left turn, wrapping inside 0..NUM_ANGLES-1.
module heading_step #(
    parameter int NUM_ANGLES = 126,
    parameter int TURN_STEP  = 1
) (
    input  logic [6:0] idx,
    input  logic       turn_left,
    input  logic       turn_right,
    output logic [6:0] next_idx
);

    logic        [7:0] step8;
    logic        [7:0] num8;
    logic        [7:0] sum;
    logic signed [7:0] diff;
    logic        [6:0] right_idx;
    logic        [6:0] left_idx;

    assign step8 = 8'(TURN_STEP);
    assign num8  = 8'(NUM_ANGLES);

    // Both sums are kept at 8 bits so the wrap compare sees the carry/borrow
    assign sum  = {1'b0, idx} + step8;
    assign diff = signed'({1'b0, idx}) - signed'(step8);

    assign right_idx = 7'((sum >= num8) ? (sum - num8) : sum);
    assign left_idx  = 7'((diff < 0) ? (diff + signed'(num8)) : diff);

    always_comb begin
        next_idx = idx;
        if (turn_right && !turn_left) begin
            next_idx = right_idx;
        end else if (turn_left && !turn_right) begin
            next_idx = left_idx;
        end
    end

endmodule

// File: rtl/heading_ctrl.sv
// Heading controller: steps the heading index once per frame on a turn
// request, reads the matching angle_rom word and publishes the camera set.
module heading_ctrl #(
    parameter int NUM_ANGLES = 126,
    parameter int TURN_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        turn_left,
    input  logic        turn_right,
    output logic [6:0]  rom_addr,
    input  logic [79:0] rom_data,
    output logic [15:0] dir_x,
    output logic [15:0] dir_y,
    output logic [15:0] plane_x,
    output logic [15:0] plane_y,
    output logic [15:0] inv_det,
    output logic [6:0]  heading,
    output logic        params_valid,
    output logic        updated,
    output logic        busy
);

    import fpdoom_pkg::*;

    state_t     state;
    state_t     next_state;
    logic       load_heading;
    logic [6:0] next_idx;

    heading_step #(
        .NUM_ANGLES (NUM_ANGLES),
        .TURN_STEP  (TURN_STEP)
    ) u_step (
        .idx        (heading),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .next_idx   (next_idx)
    );

    always_comb begin
        next_state   = state;
        load_heading = 1'b0;
        case (state)
            ST_INIT: next_state = ST_REQ;
            ST_IDLE: begin
                // Only an unambiguous turn request starts a reload
                if (frame_start && (turn_left ^ turn_right)) begin
                    load_heading = 1'b1;
                    next_state   = ST_REQ;
                end
            end
            ST_REQ:  next_state = ST_CAPT;
            ST_CAPT: next_state = ST_IDLE;
            default: next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            heading      <= '0;
            dir_x        <= '0;
            dir_y        <= '0;
            plane_x      <= '0;
            plane_y      <= '0;
            inv_det      <= '0;
            params_valid <= 1'b0;
            updated      <= 1'b0;
        end else begin
            state   <= next_state;
            updated <= 1'b0;
            if (load_heading) begin
                heading <= next_idx;
            end
            // All five fields move together so no output mixes two headings
            if (state == ST_CAPT) begin
                dir_x        <= rom_data[DIR_X_LSB   +: FIELD_W];
                dir_y        <= rom_data[DIR_Y_LSB   +: FIELD_W];
                plane_x      <= rom_data[PLANE_X_LSB +: FIELD_W];
                plane_y      <= rom_data[PLANE_Y_LSB +: FIELD_W];
                inv_det      <= rom_data[INV_DET_LSB +: FIELD_W];
                params_valid <= 1'b1;
                updated      <= 1'b1;
            end
        end
    end

    assign rom_addr = heading;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_heading_ctrl.sv
// Directed bench for heading_ctrl: one instance with TURN_STEP=1 and one
// with TURN_STEP=5, each fed by a registered angle_rom model.
module tb_heading_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Deterministic, per-address distinct ROM contents
    function automatic logic [79:0] rom_word(input logic [6:0] a);
        logic [15:0] w;
        logic [15:0] f0, f1, f2, f3, f4;
        w  = {9'd0, a};
        f0 = w * 16'd3 + 16'h0100;
        f1 = w ^ 16'h5A5A;
        f2 = 16'd0 - w;
        f3 = w << 4;
        f4 = 16'hF000 | w;
        return {f0, f1, f2, f3, f4};
    endfunction

    // ---------------- instance A: TURN_STEP = 1 ----------------
    logic        rst_n_a = 1'b0, fs_a = 1'b0, tl_a = 1'b0, tr_a = 1'b0;
    logic [6:0]  addr_a, head_a;
    logic [79:0] data_a = '0;
    logic [15:0] dx_a, dy_a, px_a, py_a, id_a;
    logic        pv_a, upd_a, busy_a;

    heading_ctrl #(.NUM_ANGLES(126), .TURN_STEP(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .frame_start(fs_a),
        .turn_left(tl_a), .turn_right(tr_a),
        .rom_addr(addr_a), .rom_data(data_a),
        .dir_x(dx_a), .dir_y(dy_a), .plane_x(px_a), .plane_y(py_a),
        .inv_det(id_a), .heading(head_a), .params_valid(pv_a),
        .updated(upd_a), .busy(busy_a)
    );

    always @(posedge clk) data_a <= rom_word(addr_a);

    // ---------------- instance B: TURN_STEP = 5 ----------------
    logic        rst_n_b = 1'b0, fs_b = 1'b0, tl_b = 1'b0, tr_b = 1'b0;
    logic [6:0]  addr_b, head_b;
    logic [79:0] data_b = '0;
    logic [15:0] dx_b, dy_b, px_b, py_b, id_b;
    logic        pv_b, upd_b, busy_b;

    heading_ctrl #(.NUM_ANGLES(126), .TURN_STEP(5)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .frame_start(fs_b),
        .turn_left(tl_b), .turn_right(tr_b),
        .rom_addr(addr_b), .rom_data(data_b),
        .dir_x(dx_b), .dir_y(dy_b), .plane_x(px_b), .plane_y(py_b),
        .inv_det(id_b), .heading(head_b), .params_valid(pv_b),
        .updated(upd_b), .busy(busy_b)
    );

    always @(posedge clk) data_b <= rom_word(addr_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] cam_a();
        return {dx_a, dy_a, px_a, py_a, id_a};
    endfunction

    function automatic logic [79:0] cam_b();
        return {dx_b, dy_b, px_b, py_b, id_b};
    endfunction

    initial begin
        #1;
        // Reset held
        step(); step();
        check("rst_busy",    80'(busy_a), 80'd1);
        check("rst_heading", 80'(head_a), 80'd0);
        check("rst_pv",      80'(pv_a),   80'd0);
        check("rst_upd",     80'(upd_a),  80'd0);
        check("rst_cam",     cam_a(),     80'd0);

        // Reset release: load of entry 0 completes after 3 edges
        rst_n_a = 1'b1;
        step();
        check("rel1_busy", 80'(busy_a), 80'd1);
        check("rel1_upd",  80'(upd_a),  80'd0);
        step();
        check("rel2_pv",   80'(pv_a),   80'd0);
        step();
        check("rel3_upd",  80'(upd_a),  80'd1);
        check("rel3_pv",   80'(pv_a),   80'd1);
        check("rel3_head", 80'(head_a), 80'd0);
        check("rel3_cam",  cam_a(),     rom_word(7'd0));
        check("rel3_busy", 80'(busy_a), 80'd0);
        step();
        check("rel4_upd",  80'(upd_a),  80'd0);
        check("rel4_pv",   80'(pv_a),   80'd1);

        // Left turn at 0 wraps to 125
        fs_a = 1'b1; tl_a = 1'b1;
        step();
        fs_a = 1'b0; tl_a = 1'b0;
        check("l0_head", 80'(head_a), 80'd125);
        check("l0_busy", 80'(busy_a), 80'd1);
        step();
        step();
        check("l0_upd",  80'(upd_a), 80'd1);
        check("l0_cam",  cam_a(),    rom_word(7'd125));

        // Right turn at 125 wraps to 0; busy exactly two cycles
        step();
        fs_a = 1'b1; tr_a = 1'b1;
        step();
        fs_a = 1'b0; tr_a = 1'b0;
        check("r125_head",  80'(head_a), 80'd0);
        check("r125_busy1", 80'(busy_a), 80'd1);
        check("r125_lag",   cam_a(),     rom_word(7'd125));
        step();
        check("r125_busy2", 80'(busy_a), 80'd1);
        check("r125_upd0",  80'(upd_a),  80'd0);
        step();
        check("r125_busy3", 80'(busy_a), 80'd0);
        check("r125_upd",   80'(upd_a),  80'd1);
        check("r125_cam",   cam_a(),     rom_word(7'd0));

        // Both turn inputs: no change, no load
        step();
        fs_a = 1'b1; tl_a = 1'b1; tr_a = 1'b1;
        step();
        fs_a = 1'b0; tl_a = 1'b0; tr_a = 1'b0;
        check("both_head", 80'(head_a), 80'd0);
        check("both_busy", 80'(busy_a), 80'd0);
        step();
        check("both_upd",  80'(upd_a),  80'd0);
        check("both_cam",  cam_a(),     rom_word(7'd0));

        // Neither turn input
        fs_a = 1'b1;
        step();
        fs_a = 1'b0;
        check("none_busy", 80'(busy_a), 80'd0);
        check("none_head", 80'(head_a), 80'd0);

        // frame_start held during REQ/CAPT is ignored: single advance
        fs_a = 1'b1; tr_a = 1'b1;
        step();
        check("ign_head0", 80'(head_a), 80'd1);
        step();
        step();
        fs_a = 1'b0; tr_a = 1'b0;
        check("ign_upd",   80'(upd_a),  80'd1);
        check("ign_head1", 80'(head_a), 80'd1);
        check("ign_cam",   cam_a(),     rom_word(7'd1));
        step();
        check("ign_busy",  80'(busy_a), 80'd0);
        check("ign_head2", 80'(head_a), 80'd1);

        // Reset asserted while in CAPT
        fs_a = 1'b1; tr_a = 1'b1;
        step();
        fs_a = 1'b0; tr_a = 1'b0;
        check("rc_head", 80'(head_a), 80'd2);
        step();
        rst_n_a = 1'b0;
        step();
        check("rc_cam",  cam_a(),     80'd0);
        check("rc_pv",   80'(pv_a),   80'd0);
        check("rc_upd",  80'(upd_a),  80'd0);
        check("rc_hd",   80'(head_a), 80'd0);
        check("rc_busy", 80'(busy_a), 80'd1);
        rst_n_a = 1'b1;
        step();
        check("rc1_upd", 80'(upd_a), 80'd0);
        step();
        check("rc2_upd", 80'(upd_a), 80'd0);
        check("rc2_pv",  80'(pv_a),  80'd0);
        step();
        check("rc3_upd", 80'(upd_a), 80'd1);
        check("rc3_cam", cam_a(),    rom_word(7'd0));

        // Instance B: TURN_STEP = 5
        rst_n_b = 1'b1;
        step(); step(); step();
        check("b_rel_pv", 80'(pv_b), 80'd1);
        step();
        fs_b = 1'b1; tl_b = 1'b1;
        step();
        fs_b = 1'b0; tl_b = 1'b0;
        check("b_l_head", 80'(head_b), 80'd121);
        step(); step();
        check("b_l_upd",  80'(upd_b), 80'd1);
        check("b_l_cam",  cam_b(),     rom_word(7'd121));
        step();
        fs_b = 1'b1; tr_b = 1'b1;
        step();
        fs_b = 1'b0; tr_b = 1'b0;
        check("b_r_head", 80'(head_b), 80'd0);
        step(); step();
        check("b_r_cam",  cam_b(),     rom_word(7'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
